// File: rtl/branch_resolver_pkg.sv
// Shared definitions for the branch resolver: condition-flag indices into the
// CMP flag register and the condition-select result type.
package branch_resolver_pkg;

   localparam int COND_W   = 4;
   localparam int NUM_COND = 12;

   // Bit positions of each flag in the CMP result register.
   localparam logic [COND_W-1:0] COND_GT     = 4'd0;
   localparam logic [COND_W-1:0] COND_LE     = 4'd1;
   localparam logic [COND_W-1:0] COND_GE     = 4'd2;
   localparam logic [COND_W-1:0] COND_LT     = 4'd3;
   localparam logic [COND_W-1:0] COND_GTU    = 4'd4;
   localparam logic [COND_W-1:0] COND_LEU    = 4'd5;
   localparam logic [COND_W-1:0] COND_GEU    = 4'd6;
   localparam logic [COND_W-1:0] COND_LTU    = 4'd7;
   localparam logic [COND_W-1:0] COND_NE     = 4'd8;
   localparam logic [COND_W-1:0] COND_EQ     = 4'd9;
   localparam logic [COND_W-1:0] COND_NEVER  = 4'd10;
   localparam logic [COND_W-1:0] COND_ALWAYS = 4'd11;
   localparam logic [COND_W-1:0] COND_MAX    = 4'd11;

   typedef struct packed {
      logic taken;
      logic illegal;
   } cond_sel_t;

endpackage

// File: rtl/branch_cond_mux.sv
// Combinational 12:1 select of the CMP flag register by condition index.
// never/always are forced regardless of the flag register contents.
module branch_cond_mux
   import branch_resolver_pkg::*;
(
   input  logic [NUM_COND-1:0] comp_reg,
   input  logic [COND_W-1:0]   sel,
   output logic                bit_out,
   output logic                illegal
);

   cond_sel_t res;

   always_comb begin
      res = '0;
      case (sel)
         COND_GT:     res.taken = comp_reg[COND_GT];
         COND_LE:     res.taken = comp_reg[COND_LE];
         COND_GE:     res.taken = comp_reg[COND_GE];
         COND_LT:     res.taken = comp_reg[COND_LT];
         COND_GTU:    res.taken = comp_reg[COND_GTU];
         COND_LEU:    res.taken = comp_reg[COND_LEU];
         COND_GEU:    res.taken = comp_reg[COND_GEU];
         COND_LTU:    res.taken = comp_reg[COND_LTU];
         COND_NE:     res.taken = comp_reg[COND_NE];
         COND_EQ:     res.taken = comp_reg[COND_EQ];
         COND_NEVER:  res.taken = 1'b0;
         COND_ALWAYS: res.taken = 1'b1;
         default:     res.illegal = (sel > COND_MAX);
      endcase
   end

   assign bit_out = res.taken;
   assign illegal = res.illegal;

endmodule

// File: rtl/branch_resolver.sv
// Branch resolver: waits out in-flight CMPs, resolves one branch at a time and
// flushes fetch after taken branches. Define BRANCH_STATS_EN for taken/total counters.
module branch_resolver
   import branch_resolver_pkg::*;
#(
   parameter int ADDR_W       = 16,
   parameter int FLUSH_CYCLES = 2
`ifdef BRANCH_STATS_EN
   ,parameter int STAT_W      = 16
`endif
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_COND-1:0] i_comp_reg,
   input  logic                i_cmp_pending,
   input  logic                i_br_valid,
   input  logic [COND_W-1:0]   i_br_cond,
   input  logic [ADDR_W-1:0]   i_br_target,
   input  logic [ADDR_W-1:0]   i_br_pc,
   output logic                o_br_ready,
   output logic                o_resolve_valid,
   output logic                o_br_taken,
   output logic [ADDR_W-1:0]   o_redirect_pc,
   output logic                o_flush,
   output logic                o_illegal_cond
`ifdef BRANCH_STATS_EN
   ,output logic [STAT_W-1:0]  o_taken_cnt,
   output logic [STAT_W-1:0]   o_total_cnt
`endif
);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_WAIT  = 3'd1;
   localparam logic [2:0] ST_EVAL  = 3'd2;
   localparam logic [2:0] ST_RESP  = 3'd3;
   localparam logic [2:0] ST_FLUSH = 3'd4;

   localparam int                FCNT_W     = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [FCNT_W-1:0] FLUSH_LOAD = FCNT_W'(FLUSH_CYCLES - 1);

   logic [2:0]        state;
   logic [COND_W-1:0] cond_q;
   logic [ADDR_W-1:0] target_q;
   logic [ADDR_W-1:0] pc_q;
   logic [FCNT_W-1:0] flush_cnt;
   logic              sel_bit;
   logic              sel_illegal;

   branch_cond_mux u_cond_mux (
      .comp_reg (i_comp_reg),
      .sel      (cond_q),
      .bit_out  (sel_bit),
      .illegal  (sel_illegal)
   );

   // Held low during reset even though the state register already reads IDLE.
   assign o_br_ready = (state == ST_IDLE) && !reset;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state           <= ST_IDLE;
         cond_q          <= '0;
         target_q        <= '0;
         pc_q            <= '0;
         flush_cnt       <= '0;
         o_resolve_valid <= 1'b0;
         o_br_taken      <= 1'b0;
         o_redirect_pc   <= '0;
         o_flush         <= 1'b0;
         o_illegal_cond  <= 1'b0;
      end else begin
         o_resolve_valid <= 1'b0;
         o_illegal_cond  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (i_br_valid) begin
                  cond_q   <= i_br_cond;
                  target_q <= i_br_target;
                  pc_q     <= i_br_pc;
                  state    <= i_cmp_pending ? ST_WAIT : ST_EVAL;
               end
            end
            ST_WAIT: begin
               if (!i_cmp_pending) state <= ST_EVAL;
            end
            // Only state that looks at the flag register.
            ST_EVAL: begin
               o_resolve_valid <= 1'b1;
               o_br_taken      <= sel_bit;
               o_illegal_cond  <= sel_illegal;
               o_redirect_pc   <= sel_bit ? target_q : pc_q + ADDR_W'(1);
               state           <= ST_RESP;
            end
            ST_RESP: begin
               if (o_br_taken) begin
                  o_flush   <= 1'b1;
                  flush_cnt <= FLUSH_LOAD;
                  state     <= ST_FLUSH;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_FLUSH: begin
               if (flush_cnt == '0) begin
                  o_flush <= 1'b0;
                  state   <= ST_IDLE;
               end else begin
                  flush_cnt <= flush_cnt - 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef BRANCH_STATS_EN
   // Counted in RESP, where o_br_taken holds the result of this branch.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         o_taken_cnt <= '0;
         o_total_cnt <= '0;
      end else if (state == ST_RESP) begin
         if (!(&o_total_cnt))              o_total_cnt <= o_total_cnt + 1'b1;
         if (o_br_taken && !(&o_taken_cnt)) o_taken_cnt <= o_taken_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver with an expected-result queue; build with
// BRANCH_STATS_EN defined to also exercise the statistics counters.
module tb_branch_resolver;

   localparam int ADDR_W = 16;
   localparam int FC     = 2;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [11:0]       i_comp_reg = '0;
   logic              i_cmp_pending = 1'b0;
   logic              i_br_valid = 1'b0;
   logic [3:0]        i_br_cond = '0;
   logic [ADDR_W-1:0] i_br_target = '0;
   logic [ADDR_W-1:0] i_br_pc = '0;
   logic              o_br_ready, o_resolve_valid, o_br_taken, o_flush, o_illegal_cond;
   logic [ADDR_W-1:0] o_redirect_pc;
`ifdef BRANCH_STATS_EN
   logic [3:0]        o_taken_cnt, o_total_cnt;
`endif

   branch_resolver #(
      .ADDR_W(ADDR_W), .FLUSH_CYCLES(FC)
`ifdef BRANCH_STATS_EN
      , .STAT_W(4)
`endif
   ) dut (
      .clk(clk), .reset(reset), .i_comp_reg(i_comp_reg), .i_cmp_pending(i_cmp_pending),
      .i_br_valid(i_br_valid), .i_br_cond(i_br_cond), .i_br_target(i_br_target),
      .i_br_pc(i_br_pc), .o_br_ready(o_br_ready), .o_resolve_valid(o_resolve_valid),
      .o_br_taken(o_br_taken), .o_redirect_pc(o_redirect_pc), .o_flush(o_flush),
      .o_illegal_cond(o_illegal_cond)
`ifdef BRANCH_STATS_EN
      , .o_taken_cnt(o_taken_cnt), .o_total_cnt(o_total_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic              taken;
      logic [ADDR_W-1:0] redir;
      logic              ill;
      int                lat;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one request; optionally hold i_cmp_pending for 'pend' cycles from
   // the accept cycle and load 'comp_after' when it drops.
   task automatic issue(input logic [3:0] cond, input logic [ADDR_W-1:0] tgt,
                        input logic [ADDR_W-1:0] pc, input logic exp_taken,
                        input logic exp_ill, input int pend, input logic [11:0] comp_after);
      exp_t e;
      int   lat;
      @(negedge clk);
      chk("ready_at_accept", 32'(o_br_ready), 32'd1);
      i_br_valid  = 1'b1;
      i_br_cond   = cond;
      i_br_target = tgt;
      i_br_pc     = pc;
      if (pend > 0) i_cmp_pending = 1'b1;
      e.taken = exp_taken;
      e.redir = exp_taken ? tgt : pc + 16'd1;
      e.ill   = exp_ill;
      e.lat   = 2 + pend;
      sb.push_back(e);
      lat = 0;
      do begin
         @(negedge clk);
         i_br_valid = 1'b0;
         lat++;
         if (pend > 0 && lat == pend) begin
            i_cmp_pending = 1'b0;
            i_comp_reg    = comp_after;
         end
      end while (!o_resolve_valid && lat < 30);
      e = sb.pop_front();
      chk("resolve_latency", 32'(lat), 32'(e.lat));
      chk("taken", 32'(o_br_taken), 32'(e.taken));
      chk("redirect_pc", 32'(o_redirect_pc), 32'(e.redir));
      chk("illegal_cond", 32'(o_illegal_cond), 32'(e.ill));
   endtask

   // Follow the tail of a resolution until ready returns.
   task automatic drain(input logic exp_taken);
      int n  = 0;
      int fl = 0;
      do begin
         @(negedge clk);
         n++;
         if (n == 1) begin
            chk("resolve_one_cycle", 32'(o_resolve_valid), 32'd0);
            chk("illegal_one_cycle", 32'(o_illegal_cond), 32'd0);
         end
         if (o_flush) fl++;
      end while (!o_br_ready && n < 30);
      chk("ready_return_cycles", 32'(n), exp_taken ? 32'(1 + FC) : 32'd1);
      chk("flush_cycles", 32'(fl), exp_taken ? 32'(FC) : 32'd0);
   endtask

   initial begin
      #1;
      chk("rst_ready", 32'(o_br_ready), 32'd0);
      chk("rst_resolve", 32'(o_resolve_valid), 32'd0);
      chk("rst_taken", 32'(o_br_taken), 32'd0);
      chk("rst_redirect", 32'(o_redirect_pc), 32'd0);
      chk("rst_flush", 32'(o_flush), 32'd0);
      chk("rst_illegal", 32'(o_illegal_cond), 32'd0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1 chk("ready_after_rst", 32'(o_br_ready), 32'd1);

      // always-taken
      i_comp_reg = 12'h800;
      issue(4'd11, 16'h0040, 16'h0000, 1'b1, 1'b0, 0, 12'h800);
      drain(1'b1);
      // eq clear -> fall through
      issue(4'd9, 16'h1234, 16'h0010, 1'b0, 1'b0, 0, 12'h800);
      drain(1'b0);
      // pending CMP, eq set on release
      issue(4'd9, 16'h0080, 16'h0020, 1'b1, 1'b0, 3, 12'hA00);
      drain(1'b1);
      // illegal condition
      issue(4'hE, 16'h0100, 16'h0030, 1'b0, 1'b1, 0, 12'hA00);
      drain(1'b0);
      // never with every flag set, always with none
      i_comp_reg = 12'hFFF;
      issue(4'd10, 16'h0500, 16'h0050, 1'b0, 1'b0, 0, 12'hFFF);
      drain(1'b0);
      i_comp_reg = 12'h000;
      issue(4'd11, 16'h0600, 16'h0060, 1'b1, 1'b0, 0, 12'h000);
      drain(1'b1);
      // ordinary flags
      i_comp_reg = 12'h010;
      issue(4'd4, 16'h0700, 16'h0070, 1'b1, 1'b0, 0, 12'h010);
      drain(1'b1);
      i_comp_reg = 12'hFFE;
      issue(4'd0, 16'h0800, 16'h0080, 1'b0, 1'b0, 0, 12'hFFE);
      drain(1'b0);

      // reset in the middle of a flush
      i_comp_reg = 12'h800;
      issue(4'd11, 16'h0200, 16'h0040, 1'b1, 1'b0, 0, 12'h800);
      @(negedge clk);
      chk("flush_before_rst", 32'(o_flush), 32'd1);
      reset = 1'b1;
      #1;
      chk("flush_cleared_rst", 32'(o_flush), 32'd0);
      chk("resolve_cleared_rst", 32'(o_resolve_valid), 32'd0);
      chk("ready_low_in_rst", 32'(o_br_ready), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      #1 chk("ready_after_mid_rst", 32'(o_br_ready), 32'd1);
      // pc+1 wraps
      i_comp_reg = 12'h000;
      issue(4'd9, 16'h0300, 16'hFFFF, 1'b0, 1'b0, 0, 12'h000);
      drain(1'b0);

`ifdef BRANCH_STATS_EN
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("stats_rst_taken", 32'(o_taken_cnt), 32'd0);
      chk("stats_rst_total", 32'(o_total_cnt), 32'd0);
      i_comp_reg = 12'h800;
      issue(4'd11, 16'h0400, 16'h0000, 1'b1, 1'b0, 0, 12'h800);
      drain(1'b1);
      chk("stats_one_taken", 32'(o_taken_cnt), 32'd1);
      chk("stats_one_total", 32'(o_total_cnt), 32'd1);
      for (int i = 0; i < 19; i++) begin
         issue(4'd11, 16'h0400, 16'(i), 1'b1, 1'b0, 0, 12'h800);
         drain(1'b1);
      end
      chk("stats_sat_taken", 32'(o_taken_cnt), 32'hF);
      chk("stats_sat_total", 32'(o_total_cnt), 32'hF);
`else
      $display("statistics counters not built; skipping counter steps");
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
